// File: rtl/maga_pkg.sv
// Shared state encodings, baud table and limits for the MAGA UART bridge.
package maga_pkg;

  // RX FSM encodings
  localparam logic [2:0] RX_IDLE = 3'd0;
  localparam logic [2:0] RX_RD   = 3'd1;
  localparam logic [2:0] RX_WAIT = 3'd2;
  localparam logic [2:0] RX_CAP  = 3'd3;
  localparam logic [2:0] RX_GAP  = 3'd4;

  // TX FSM encodings
  localparam logic [1:0] TX_IDLE = 2'd0;
  localparam logic [1:0] TX_WR   = 2'd1;
  localparam logic [1:0] TX_HOLD = 2'd2;

  // Fault FSM encodings
  localparam logic [1:0] FLT_RUN     = 2'd0;
  localparam logic [1:0] FLT_FAULT   = 2'd1;
  localparam logic [1:0] FLT_RECOVER = 2'd2;

  // Baud divisor table
  localparam int unsigned BAUD_325 = 325;
  localparam int unsigned BAUD_162 = 162;
  localparam int unsigned BAUD_80  = 80;
  localparam int unsigned BAUD_26  = 26;

  localparam logic [7:0] FAULT_CNT_MAX = 8'd255;

  // Map the 2-bit baud select onto a divisor
  function automatic int unsigned baud_lookup(input logic [1:0] sel);
    case (sel)
      2'd0:    return BAUD_325;
      2'd1:    return BAUD_162;
      2'd2:    return BAUD_80;
      default: return BAUD_26;
    endcase
  endfunction

endpackage

// File: rtl/maga_sync_fifo.sv
// Synchronous relay FIFO with push/pop/flush; flush wins over push and pop.
module maga_sync_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  localparam int unsigned AW        = $clog2(FIFO_DEPTH),
  localparam int unsigned LW        = AW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic [LW-1:0]     level,
  output logic              full,
  output logic              empty
);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]     level_q, level_d;
  logic              do_push, do_pop;

  assign full    = (level_q == LW'(FIFO_DEPTH));
  assign empty   = (level_q == '0);
  assign level   = level_q;
  assign rdata   = mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // Next-state for storage, pointers (wrap naturally, depth is a power of 2) and level
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q + LW'(do_push) - LW'(do_pop);
    if (do_push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end
  end

  // Pointer and level registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage array, contents are don't-care until written
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/maga_uart_bridge.sv
// UART-to-MAGA relay: RX drain FSM, buffered TX forwarding, fault shutdown/recovery, baud select.
// Optional MAGA_BRIDGE_STATS_EN adds RX_CNT/TX_CNT byte counters.
module maga_uart_bridge
  import maga_pkg::*;
#(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned FIFO_DEPTH  = 16,
  parameter int unsigned RD_LAT      = 2,
  parameter int unsigned RECOVER_CYC = 1000,
  parameter int unsigned BAUD_W      = 13
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        MAGA_FLT,
  input  logic                        MAGA_READY,
  input  logic                        TXrd,
  input  logic                        RXrd,
  input  logic [DATA_W-1:0]           RX,
  input  logic [1:0]                  BAUD_SEL,
  output logic [BAUD_W-1:0]           BAUD_val,
  output logic [DATA_W-1:0]           TX,
  output logic                        OEN,
  output logic                        WEN,
  output logic                        MAGA_EN,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_LEVEL,
  output logic                        OVERRUN,
  output logic [7:0]                  FAULT_CNT
`ifdef MAGA_BRIDGE_STATS_EN
 ,output logic [15:0]                 RX_CNT,
  output logic [15:0]                 TX_CNT
`endif
);

  localparam int unsigned RC_W = (RECOVER_CYC > 1) ? $clog2(RECOVER_CYC) : 1;

  logic [2:0]        rx_state_q, rx_state_d;
  logic [2:0]        rx_wait_q, rx_wait_d;
  logic [1:0]        tx_state_q, tx_state_d;
  logic              tx_hold_q, tx_hold_d;
  logic [1:0]        flt_state_q, flt_state_d;
  logic [RC_W-1:0]   rec_cnt_q, rec_cnt_d;
  logic [7:0]        fault_cnt_q, fault_cnt_d;
  logic [BAUD_W-1:0] baud_q, baud_d;

  logic              push, pop, flush, overrun, flt_ok;
  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  // Running and no fault arriving this cycle: safe to push or start a write
  assign flt_ok = (flt_state_q == FLT_RUN) && !MAGA_FLT;

  maga_sync_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (RX),
    .rdata (fifo_head),
    .level (FIFO_LEVEL),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Fault FSM: count the fault, flush, hold MAGA off, then wait for MAGA to come back ready
  always_comb begin
    flt_state_d = flt_state_q;
    rec_cnt_d   = rec_cnt_q;
    fault_cnt_d = fault_cnt_q;
    flush       = 1'b0;
    case (flt_state_q)
      FLT_RUN: if (MAGA_FLT) begin
        flt_state_d = FLT_FAULT;
        rec_cnt_d   = '0;
        flush       = 1'b1;
        if (fault_cnt_q != FAULT_CNT_MAX) fault_cnt_d = fault_cnt_q + 8'd1;
      end
      FLT_FAULT: begin
        if (MAGA_FLT)                               rec_cnt_d   = '0;
        else if (rec_cnt_q == RC_W'(RECOVER_CYC-1)) flt_state_d = FLT_RECOVER;
        else                                        rec_cnt_d   = rec_cnt_q + 1'b1;
      end
      FLT_RECOVER: if (MAGA_READY && !MAGA_FLT) flt_state_d = FLT_RUN;
      default: flt_state_d = FLT_RUN;
    endcase
  end

  // RX FSM: strobe OEN, wait out the read latency, capture, then leave a gap for RXrd to drop
  always_comb begin
    rx_state_d = rx_state_q;
    rx_wait_d  = rx_wait_q;
    push       = 1'b0;
    overrun    = 1'b0;
    case (rx_state_q)
      RX_IDLE: if (RXrd && (flt_state_q == FLT_RUN)) rx_state_d = RX_RD;
      RX_RD: begin
        rx_wait_d  = '0;
        rx_state_d = (RD_LAT == 1) ? RX_CAP : RX_WAIT;
      end
      RX_WAIT: begin
        if (rx_wait_q == 3'(RD_LAT-2)) rx_state_d = RX_CAP;
        else                           rx_wait_d  = rx_wait_q + 3'd1;
      end
      RX_CAP: begin
        // Byte is always consumed from the UART; only stored when running and not full
        if (flt_ok) begin
          if (!fifo_full) push    = 1'b1;
          else            overrun = 1'b1;
        end
        rx_state_d = RX_GAP;
      end
      RX_GAP:  rx_state_d = RX_IDLE;
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // TX FSM: one-cycle write strobe with pop, then two hold cycles
  always_comb begin
    tx_state_d = tx_state_q;
    tx_hold_d  = tx_hold_q;
    pop        = 1'b0;
    case (tx_state_q)
      TX_IDLE: if (!fifo_empty && TXrd && MAGA_READY && flt_ok) tx_state_d = TX_WR;
      TX_WR: begin
        pop        = !fifo_empty;
        tx_hold_d  = 1'b0;
        tx_state_d = TX_HOLD;
      end
      TX_HOLD: begin
        if (tx_hold_q) tx_state_d = TX_IDLE;
        else           tx_hold_d  = 1'b1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  // Baud divisor only changes while the bridge is fully quiescent
  always_comb begin
    baud_d = baud_q;
    if ((rx_state_q == RX_IDLE) && (tx_state_q == TX_IDLE) && fifo_empty)
      baud_d = BAUD_W'(baud_lookup(BAUD_SEL));
  end

  // State registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_state_q  <= RX_IDLE;
      rx_wait_q   <= '0;
      tx_state_q  <= TX_IDLE;
      tx_hold_q   <= 1'b0;
      flt_state_q <= FLT_RUN;
      rec_cnt_q   <= '0;
      fault_cnt_q <= '0;
      baud_q      <= BAUD_W'(BAUD_325);
    end else begin
      rx_state_q  <= rx_state_d;
      rx_wait_q   <= rx_wait_d;
      tx_state_q  <= tx_state_d;
      tx_hold_q   <= tx_hold_d;
      flt_state_q <= flt_state_d;
      rec_cnt_q   <= rec_cnt_d;
      fault_cnt_q <= fault_cnt_d;
      baud_q      <= baud_d;
    end
  end

  assign OEN       = (rx_state_q != RX_RD);
  assign WEN       = (tx_state_q != TX_WR);
  assign TX        = (tx_state_q == TX_WR) ? fifo_head : '0;
  assign MAGA_EN   = (flt_state_q != FLT_FAULT);
  assign OVERRUN   = overrun;
  assign FAULT_CNT = fault_cnt_q;
  assign BAUD_val  = baud_q;

`ifdef MAGA_BRIDGE_STATS_EN
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;

  // Byte counters wrap freely
  always_comb begin
    rx_cnt_d = rx_cnt_q + 16'(push);
    tx_cnt_d = tx_cnt_q + 16'(pop);
  end

  // Counter registers, cleared only by reset
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rx_cnt_q <= '0;
      tx_cnt_q <= '0;
    end else begin
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
    end
  end

  assign RX_CNT = rx_cnt_q;
  assign TX_CNT = tx_cnt_q;
`endif

endmodule

// File: tb/tb_maga_uart_bridge.sv
// Directed self-checking bench for maga_uart_bridge (RD_LAT=2, RECOVER_CYC=20, depth 16).
`timescale 1ns/1ps
module tb_maga_uart_bridge;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned FIFO_DEPTH  = 16;
  localparam int unsigned RD_LAT      = 2;
  localparam int unsigned RECOVER_CYC = 20;
  localparam int unsigned BAUD_W      = 13;

  logic              CLK = 1'b0;
  logic              RESET, MAGA_FLT, MAGA_READY, TXrd, RXrd;
  logic [DATA_W-1:0] RX;
  logic [1:0]        BAUD_SEL;
  logic [BAUD_W-1:0] BAUD_val;
  logic [DATA_W-1:0] TX;
  logic              OEN, WEN, MAGA_EN, OVERRUN;
  logic [4:0]        FIFO_LEVEL;
  logic [7:0]        FAULT_CNT;
`ifdef MAGA_BRIDGE_STATS_EN
  logic [15:0]       RX_CNT, TX_CNT;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_log[$];
  int wen_cnt = 0;
  int ovr_cnt = 0;

  maga_uart_bridge #(
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .RD_LAT      (RD_LAT),
    .RECOVER_CYC (RECOVER_CYC),
    .BAUD_W      (BAUD_W)
  ) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .MAGA_FLT   (MAGA_FLT),
    .MAGA_READY (MAGA_READY),
    .TXrd       (TXrd),
    .RXrd       (RXrd),
    .RX         (RX),
    .BAUD_SEL   (BAUD_SEL),
    .BAUD_val   (BAUD_val),
    .TX         (TX),
    .OEN        (OEN),
    .WEN        (WEN),
    .MAGA_EN    (MAGA_EN),
    .FIFO_LEVEL (FIFO_LEVEL),
    .OVERRUN    (OVERRUN),
    .FAULT_CNT  (FAULT_CNT)
`ifdef MAGA_BRIDGE_STATS_EN
   ,.RX_CNT     (RX_CNT),
    .TX_CNT     (TX_CNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Record every written byte and every overrun pulse mid-cycle
  always @(negedge CLK) begin
    if (WEN === 1'b0) begin
      tx_log.push_back(TX);
      wen_cnt++;
    end
    if (OVERRUN === 1'b1) ovr_cnt++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Behave like the UART presenting one received byte
  task automatic uart_rx_byte(input logic [7:0] b);
    bit seen;
    seen = 0;
    RX   = b;
    RXrd = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      tick();
      if (OEN === 1'b0) seen = 1;
    end
    RXrd = 1'b0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL rx_strobe: OEN never went low for byte 0x%0h, required a read strobe", b);
    end
    tick(RD_LAT + 3);
  endtask

  task automatic wait_log(input int target, input string name);
    int k;
    k = 0;
    while (tx_log.size() < target && k < 400) begin
      tick();
      k++;
    end
    checks++;
    if (tx_log.size() < target) begin
      errors++;
      $display("FAIL %s: timeout, got %0d bytes, required %0d", name, tx_log.size(), target);
    end
  endtask

  task automatic test_reset();
    RESET = 1'b1; MAGA_FLT = 1'b0; MAGA_READY = 1'b0; TXrd = 1'b1;
    RXrd = 1'b0; RX = '0; BAUD_SEL = 2'd0;
    tick(3);
    checks++; if (BAUD_val !== 13'd325) begin errors++; $display("FAIL rst_baud: got %0d required 325", BAUD_val); end
    checks++; if (TX !== 8'h00)         begin errors++; $display("FAIL rst_tx: got %0h required 0", TX); end
    checks++; if (OEN !== 1'b1)         begin errors++; $display("FAIL rst_oen: got %b required 1", OEN); end
    checks++; if (WEN !== 1'b1)         begin errors++; $display("FAIL rst_wen: got %b required 1", WEN); end
    checks++; if (MAGA_EN !== 1'b1)     begin errors++; $display("FAIL rst_en: got %b required 1", MAGA_EN); end
    checks++; if (FIFO_LEVEL !== 5'd0)  begin errors++; $display("FAIL rst_level: got %0d required 0", FIFO_LEVEL); end
    checks++; if (OVERRUN !== 1'b0)     begin errors++; $display("FAIL rst_ovr: got %b required 0", OVERRUN); end
    checks++; if (FAULT_CNT !== 8'd0)   begin errors++; $display("FAIL rst_fcnt: got %0d required 0", FAULT_CNT); end
    RESET = 1'b0;
    tick();
  endtask

  task automatic test_loopback();
    MAGA_READY = 1'b1;
    RX = 8'h5A; RXrd = 1'b1;
    tick();
    checks++; if (OEN !== 1'b0) begin errors++; $display("FAIL lb_oen_low: got %b required 0", OEN); end
    RXrd = 1'b0;
    tick();
    checks++; if (OEN !== 1'b1) begin errors++; $display("FAIL lb_oen_one_cycle: got %b required 1", OEN); end
    tick(2);
    checks++; if (FIFO_LEVEL !== 5'd1) begin errors++; $display("FAIL lb_level_inc: got %0d required 1", FIFO_LEVEL); end
    tick();
    checks++; if (WEN !== 1'b0) begin errors++; $display("FAIL lb_wen: got %b required 0", WEN); end
    checks++; if (TX !== 8'h5A) begin errors++; $display("FAIL lb_tx: got %0h required 5a", TX); end
    tick();
    checks++; if (FIFO_LEVEL !== 5'd0) begin errors++; $display("FAIL lb_level_back: got %0d required 0", FIFO_LEVEL); end
    checks++; if (WEN !== 1'b1 || TX !== 8'h00) begin errors++; $display("FAIL lb_hold: got WEN=%b TX=%0h required WEN=1 TX=0", WEN, TX); end
    tick(4);
  endtask

  task automatic test_stall();
    int base_wen, base_log, base_ovr;
    MAGA_READY = 1'b0;
    base_wen = wen_cnt; base_log = tx_log.size(); base_ovr = ovr_cnt;
    for (int i = 0; i < 16; i++) uart_rx_byte(8'(i));
    checks++; if (FIFO_LEVEL !== 5'd16) begin errors++; $display("FAIL stall_level: got %0d required 16", FIFO_LEVEL); end
    checks++; if (wen_cnt != base_wen) begin errors++; $display("FAIL stall_no_wen: got %0d writes required 0", wen_cnt - base_wen); end
    uart_rx_byte(8'hAA);
    checks++; if (ovr_cnt - base_ovr != 1) begin errors++; $display("FAIL stall_overrun: got %0d pulses required 1", ovr_cnt - base_ovr); end
    checks++; if (FIFO_LEVEL !== 5'd16) begin errors++; $display("FAIL stall_level_full: got %0d required 16", FIFO_LEVEL); end
    MAGA_READY = 1'b1;
    wait_log(base_log + 16, "stall_drain");
    tick(10);
    checks++; if (tx_log.size() != base_log + 16) begin errors++; $display("FAIL stall_count: got %0d bytes required 16", tx_log.size() - base_log); end
    for (int i = 0; i < 16; i++) begin
      if (base_log + i < tx_log.size()) begin
        checks++;
        if (tx_log[base_log + i] !== 8'(i)) begin
          errors++; $display("FAIL stall_order[%0d]: got %0h required %0h", i, tx_log[base_log + i], i);
        end
      end
    end
    checks++; if (FIFO_LEVEL !== 5'd0) begin errors++; $display("FAIL stall_empty: got %0d required 0", FIFO_LEVEL); end
  endtask

  task automatic test_fault();
    int base_wen, base_log, lowcnt, k;
    MAGA_READY = 1'b0;
    for (int i = 0; i < 5; i++) uart_rx_byte(8'h30 + 8'(i));
    checks++; if (FIFO_LEVEL !== 5'd5) begin errors++; $display("FAIL flt_pre_level: got %0d required 5", FIFO_LEVEL); end
    base_wen = wen_cnt; base_log = tx_log.size();
    MAGA_FLT = 1'b1;
    tick();
    MAGA_FLT = 1'b0;
    checks++; if (MAGA_EN !== 1'b0)    begin errors++; $display("FAIL flt_en_low: got %b required 0", MAGA_EN); end
    checks++; if (FIFO_LEVEL !== 5'd0) begin errors++; $display("FAIL flt_flush: got %0d required 0", FIFO_LEVEL); end
    checks++; if (FAULT_CNT !== 8'd1)  begin errors++; $display("FAIL flt_cnt: got %0d required 1", FAULT_CNT); end
    lowcnt = 1; k = 0;
    while (k < 100) begin
      tick(); k++;
      if (MAGA_EN === 1'b0) lowcnt++;
      else break;
    end
    checks++; if (lowcnt != RECOVER_CYC) begin errors++; $display("FAIL flt_hold: got %0d cycles low required %0d", lowcnt, RECOVER_CYC); end
    checks++; if (wen_cnt != base_wen) begin errors++; $display("FAIL flt_no_wen: got %0d writes required 0", wen_cnt - base_wen); end
    MAGA_READY = 1'b1;
    tick(2);
    uart_rx_byte(8'h77);
    wait_log(base_log + 1, "flt_resume");
    tick(6);
    checks++; if (tx_log.size() != base_log + 1) begin errors++; $display("FAIL flt_resume_count: got %0d bytes required 1", tx_log.size() - base_log); end
    if (tx_log.size() > base_log) begin
      checks++;
      if (tx_log[base_log] !== 8'h77) begin errors++; $display("FAIL flt_resume_data: got %0h required 77", tx_log[base_log]); end
    end
  endtask

  task automatic test_baud();
    int base_log;
    MAGA_READY = 1'b0;
    base_log = tx_log.size();
    uart_rx_byte(8'h41);
    uart_rx_byte(8'h42);
    BAUD_SEL = 2'd2;
    tick(3);
    checks++; if (BAUD_val !== 13'd325) begin errors++; $display("FAIL baud_defer_buf: got %0d required 325", BAUD_val); end
    MAGA_READY = 1'b1;
    tick(2);
    checks++; if (BAUD_val !== 13'd325) begin errors++; $display("FAIL baud_defer_tx: got %0d required 325", BAUD_val); end
    wait_log(base_log + 2, "baud_drain");
    tick(5);
    checks++; if (BAUD_val !== 13'd80) begin errors++; $display("FAIL baud_80: got %0d required 80", BAUD_val); end
    BAUD_SEL = 2'd3;
    tick();
    checks++; if (BAUD_val !== 13'd26) begin errors++; $display("FAIL baud_26: got %0d required 26", BAUD_val); end
    BAUD_SEL = 2'd0;
    tick();
    checks++; if (BAUD_val !== 13'd325) begin errors++; $display("FAIL baud_325: got %0d required 325", BAUD_val); end
  endtask

  task automatic test_reset_mid();
    MAGA_READY = 1'b0;
    BAUD_SEL = 2'd1;
    tick(2);
    checks++; if (BAUD_val !== 13'd162) begin errors++; $display("FAIL rm_baud_162: got %0d required 162", BAUD_val); end
    uart_rx_byte(8'h11);
    RX = 8'h22; RXrd = 1'b1;
    tick();
    RXrd = 1'b0;
    tick();
    RESET = 1'b1;
    tick();
    checks++; if (OEN !== 1'b1)         begin errors++; $display("FAIL rm_oen: got %b required 1", OEN); end
    checks++; if (WEN !== 1'b1)         begin errors++; $display("FAIL rm_wen: got %b required 1", WEN); end
    checks++; if (FIFO_LEVEL !== 5'd0)  begin errors++; $display("FAIL rm_level: got %0d required 0", FIFO_LEVEL); end
    checks++; if (MAGA_EN !== 1'b1)     begin errors++; $display("FAIL rm_en: got %b required 1", MAGA_EN); end
    checks++; if (BAUD_val !== 13'd325) begin errors++; $display("FAIL rm_baud: got %0d required 325", BAUD_val); end
    checks++; if (FAULT_CNT !== 8'd0)   begin errors++; $display("FAIL rm_fcnt: got %0d required 0", FAULT_CNT); end
    RESET = 1'b0;
    BAUD_SEL = 2'd0;
    tick(4);
    checks++; if (FIFO_LEVEL !== 5'd0) begin errors++; $display("FAIL rm_no_push: got %0d required 0", FIFO_LEVEL); end
  endtask

`ifdef MAGA_BRIDGE_STATS_EN
  task automatic test_stats();
    int base_log;
    MAGA_READY = 1'b1;
    base_log = tx_log.size();
    uart_rx_byte(8'hC1);
    uart_rx_byte(8'hC2);
    uart_rx_byte(8'hC3);
    wait_log(base_log + 3, "stats_drain");
    tick(6);
    checks++; if (RX_CNT !== 16'd3) begin errors++; $display("FAIL stats_rx: got %0d required 3", RX_CNT); end
    checks++; if (TX_CNT !== 16'd3) begin errors++; $display("FAIL stats_tx: got %0d required 3", TX_CNT); end
  endtask
`endif

  initial begin
    test_reset();
    test_loopback();
    test_stall();
    test_fault();
    test_baud();
    test_reset_mid();
`ifdef MAGA_BRIDGE_STATS_EN
    test_stats();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
